// File: rtl/rx_deser_ctrl.sv
// Serial lane receive sequencer: start hunt, payload framing, stop check,
// error accounting and a small output FIFO with valid/ready handshake.
module rx_deser_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  serial_in,
   input  logic                  clr_status,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_err,
   output logic                  overflow,
   output logic [7:0]            err_count,
   output logic [15:0]           word_count,
   output logic                  busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            err_count_q, err_count_d;
   logic [15:0]           word_count_q, word_count_d;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  push_ok;
   logic                  err_evt;
   logic                  ovf_evt;
   logic [AW-1:0]         rd_nxt;

   assign out_valid  = (cnt_q != '0);
   assign full       = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign pop        = out_valid & out_ready;
   assign push       = (state_q == ST_STOP) & enable & serial_in;
   assign err_evt    = (state_q == ST_STOP) & enable & ~serial_in;
   assign push_ok    = push & (~full | pop);
   assign ovf_evt    = push & full & ~pop;
   assign rd_nxt     = rd_ptr_q + AW'(1);

   assign out_data   = out_data_q;
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;
   assign err_count  = err_count_q;
   assign word_count = word_count_q;
   assign busy       = (state_q != ST_IDLE);

   // Frame sequencer; enable low aborts any partial frame silently
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!serial_in) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA: begin
               sh_d      = {sh_q[DATA_WIDTH-2:0], serial_in};
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == CW'(DATA_WIDTH-1))
                  state_d = ST_STOP;
            end
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Status counters; a same-cycle event takes priority over clr_status
   always_comb begin
      frame_err_d  = err_evt;
      overflow_d   = overflow_q;
      err_count_d  = err_count_q;
      word_count_d = word_count_q;
      if (ovf_evt)
         overflow_d = 1'b1;
      else if (clr_status)
         overflow_d = 1'b0;
      if (err_evt) begin
         if (clr_status)
            err_count_d = 8'd1;
         else if (err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
      end else if (clr_status) begin
         err_count_d = 8'd0;
      end
      if (push_ok)
         word_count_d = word_count_q + 16'd1;
   end

   // FIFO with a registered head word that holds when empty
   always_comb begin
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = sh_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop)
         rd_ptr_d = rd_nxt;
      if (push_ok && !pop)
         cnt_d = cnt_q + (AW+1)'(1);
      else if (!push_ok && pop)
         cnt_d = cnt_q - (AW+1)'(1);
      if (pop) begin
         if (cnt_q > (AW+1)'(1))
            out_data_d = mem_q[rd_nxt];
         else if (push_ok)
            out_data_d = sh_q;
      end else if (cnt_q == '0 && push_ok) begin
         out_data_d = sh_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         sh_q         <= '0;
         frame_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
         err_count_q  <= '0;
         word_count_q <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         cnt_q        <= '0;
         out_data_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sh_q         <= sh_d;
         frame_err_q  <= frame_err_d;
         overflow_q   <= overflow_d;
         err_count_q  <= err_count_d;
         word_count_q <= word_count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
         out_data_q   <= out_data_d;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_rx_deser_ctrl.sv
// Directed bench for rx_deser_ctrl: framing, errors, FIFO overflow,
// abort, async reset and error counter saturation.
module tb_rx_deser_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        serial_in;
   logic        clr_status;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        frame_err;
   logic        overflow;
   logic [7:0]  err_count;
   logic [15:0] word_count;
   logic        busy;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   rx_deser_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .serial_in  (serial_in),
      .clr_status (clr_status),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .err_count  (err_count),
      .word_count (word_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      chk_cnt++;
      if (got === exp)
         pass_cnt++;
      else
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic clr);
      serial_in = 1'b0;
      step();
      for (int i = 7; i >= 0; i--) begin
         serial_in = d[i];
         step();
      end
      serial_in  = stop;
      clr_status = clr;
      step();
      clr_status = 1'b0;
      serial_in  = 1'b1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b1;
      serial_in  = 1'b1;
      clr_status = 1'b0;
      out_ready  = 1'b1;
      step();
      step();
      chk("rst_data", out_data, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_errc", err_count, 0);
      chk("rst_wc", word_count, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      step();
      chk("idle_busy", busy, 0);

      // 1: good frame, popped immediately
      send_frame(8'hA5, 1'b1, 1'b0);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 8'hA5);
      chk("t1_wc", word_count, 1);
      step();
      chk("t1_valid_drop", out_valid, 0);
      chk("t1_data_hold", out_data, 8'hA5);

      // 2: framing error
      send_frame(8'h3C, 1'b0, 1'b0);
      chk("t2_ferr", frame_err, 1);
      chk("t2_errc", err_count, 1);
      chk("t2_valid", out_valid, 0);
      chk("t2_wc", word_count, 1);
      step();
      chk("t2_ferr_pulse", frame_err, 0);

      // 3: overflow with consumer stalled
      pulse_rst();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++)
         send_frame(8'(k), 1'b1, 1'b0);
      chk("t3_ovf", overflow, 1);
      chk("t3_wc", word_count, 4);
      chk("t3_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("t3_pop%0d", k), out_data, k);
         step();
      end
      chk("t3_empty", out_valid, 0);
      chk("t3_ovf_sticky", overflow, 1);
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      chk("t3_ovf_clr", overflow, 0);

      // 4: abort mid payload, then a clean frame
      serial_in = 1'b0;
      step();
      serial_in = 1'b0;
      step();
      serial_in = 1'b1;
      step();
      serial_in = 1'b0;
      step();
      chk("t4_busy_pre", busy, 1);
      enable    = 1'b0;
      serial_in = 1'b1;
      step();
      chk("t4_busy_off", busy, 0);
      chk("t4_errc", err_count, 0);
      enable = 1'b1;
      step();
      chk("t4_nopush", out_valid, 0);
      chk("t4_wc_same", word_count, 4);
      send_frame(8'h5A, 1'b1, 1'b0);
      chk("t4_data", out_data, 8'h5A);
      chk("t4_wc", word_count, 5);
      step();

      // 5: async reset with a word queued and a frame in flight
      out_ready = 1'b0;
      send_frame(8'h77, 1'b1, 1'b0);
      chk("t5_pre_valid", out_valid, 1);
      serial_in = 1'b0;
      step();
      serial_in = 1'b1;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("t5_data", out_data, 0);
      chk("t5_valid", out_valid, 0);
      chk("t5_wc", word_count, 0);
      chk("t5_busy", busy, 0);
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      send_frame(8'hFF, 1'b1, 1'b0);
      chk("t5_ff_data", out_data, 8'hFF);
      chk("t5_ff_wc", word_count, 1);
      step();

      // 6: error counter saturation and clear-vs-event
      for (int k = 0; k < 256; k++)
         send_frame(8'h00, 1'b0, 1'b0);
      chk("t6_sat", err_count, 255);
      for (int k = 0; k < 4; k++)
         send_frame(8'h81, 1'b0, 1'b0);
      chk("t6_sat_hold", err_count, 255);
      chk("t6_ferr", frame_err, 1);
      send_frame(8'h81, 1'b0, 1'b1);
      chk("t6_clr_evt", err_count, 1);
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      chk("t6_clr", err_count, 0);
      chk("t6_wc", word_count, 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
